mole_whack_engine: RTL and testbench
====================================

MOLE_WHACK_ENGINE -- requirements
Module: mole_whack_engine

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, nonzero initial value of the mole-position LFSR.
REQ-002 SHALL have parameter SCORE_MAX, default 9999, saturation ceiling of score_o, so the seven-segment display path never exceeds four BCD digits.
REQ-003 SHALL have port clock_i  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port tick_i  input  1  single-cycle mole-rate strobe (1/2/5 Hz rate derived upstream, synchronous to clock_i).
REQ-006 SHALL have port game_active_i  input  1  high while a game round runs.
REQ-007 SHALL have port switches_i  input  16  raw asynchronous board switches; one switch per mole position.
REQ-008 SHALL have port leds_o  output  16  one-hot mole position, or all zero.
REQ-009 SHALL have port whack_o  output  1  one-cycle pulse on a successful whack.
REQ-010 SHALL have port miss_o  output  1  one-cycle pulse when a mole expires unwhacked.
REQ-011 SHALL have port score_o  output  16  binary hit count, consumed by the display path.
REQ-012 SHALL have port miss_count_o  output  8  binary miss count.
REQ-013 SHALL have port state_o  output  2  current FSM state: IDLE=00, SPAWN=01, UP=10, COOLDOWN=11.

Function
REQ-014 SHALL pass switches_i through stages s1->s2->s3 on every clock_i edge; edge vector = s2 XOR s3.
REQ-015 SHALL use a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1, advanced only in SPAWN.
REQ-016 SHALL transition IDLE->SPAWN when game_active_i=1 and tick_i=1; it SHALL otherwise hold IDLE with leds_o=0.
REQ-017 SHALL, in SPAWN (exactly one cycle), compute idx=lfsr[3:0]; if idx equals the previous mole index, it SHALL use idx+1 mod 16; it SHALL set leds_o=1<<idx and go to UP.
REQ-018 SHALL count as a whack, in UP, edge bit [idx]=1; it SHALL then register whack_o=1, score_o+1 (saturate at SCORE_MAX), leds_o=0 and go to COOLDOWN.
REQ-019 SHALL treat tick_i=1 in UP with no whack as a miss: it SHALL register miss_o=1, miss_count_o+1 (saturate at 255), leds_o=0 and go to COOLDOWN.
REQ-020 SHALL give the whack priority when a whack and tick_i coincide in UP; only whack_o pulses, and the state goes to COOLDOWN.
REQ-021 SHALL ignore edges on switches other than idx, and SHALL ignore all edges outside UP.
REQ-022 SHALL transition COOLDOWN->SPAWN on tick_i=1; tick_i in SPAWN SHALL be ignored.
REQ-023 SHALL force, from any state with game_active_i=0, the next state to IDLE and leds_o=0; score_o and miss_count_o SHALL be held.
REQ-024 SHALL clear score_o, miss_count_o and the previous-index register to 0 on a 0->1 transition of game_active_i; the LFSR SHALL keep running.
REQ-025 SHALL make a switch change first sampled into s1 at edge N visible on whack_o, score_o and leds_o after edge N+2 (fixed latency).
REQ-026 SHALL register all outputs; whack_o and miss_o SHALL never be high for two consecutive cycles.

Reset
REQ-027 SHALL, on reset_i=1 at a clock_i edge, set: state IDLE, leds_o=0, whack_o=0, miss_o=0, score_o=0, miss_count_o=0, lfsr=SEED, previous index=0.
REQ-028 SHALL load s1, s2 and s3 with switches_i on reset, so that switches already up produce no spurious edge.
REQ-029 SHALL let reset_i override every other input, including mid-UP and coincident tick_i.

Verification
REQ-030 SHALL be covered by: reset with switches_i=16'hFFFF, then game_active_i=1 and tick_i -> no whack_o; SPAWN for one cycle; leds_o one-hot from SEED-derived idx.
REQ-031 SHALL be covered by: mole at idx=5, toggle switches_i[5] sampled at edge N -> whack_o=1 and leds_o=0 after edge N+2, score_o 0->1, state COOLDOWN.
REQ-032 SHALL be covered by: mole up, tick_i with no toggle -> miss_o=1 for one cycle, miss_count_o=1, leds_o=0; on the next tick_i a new mole appears at an index different from the previous one.
REQ-033 SHALL be covered by: whack edge and tick_i in the same UP cycle -> whack_o=1, miss_o=0, score_o increments.
REQ-034 SHALL be covered by: score_o preloaded to 9999 via repeated whacks, one more whack -> whack_o=1 and score_o stays 9999.
REQ-035 SHALL be covered by: game_active_i dropped mid-UP -> IDLE and leds_o=0 next cycle, score_o held; on re-raise -> score_o=0 and miss_count_o=0.

Source files
------------

// File: rtl/mole_whack_engine.sv
// mole_whack_engine
//   Whack-a-mole game core. One mole is shown at a time on a 16-LED bar, at
//   a pseudo-random position from a 16-bit Fibonacci LFSR. The player hits a
//   mole by flipping the matching board switch. A flip in either direction
//   counts. If the mole-rate tick arrives first, the mole counts as a miss.
//
// Parameters
//   SEED       nonzero LFSR start value
//   SCORE_MAX  saturation ceiling of score_o
//
// Ports
//   clock_i        system clock
//   reset_i        synchronous, active-high reset
//   tick_i         one-cycle mole-rate strobe
//   game_active_i  high while a round runs; a rising edge clears the counters
//   switches_i     raw asynchronous board switches, one per mole position
//   leds_o         one-hot mole position, or all zero
//   whack_o        one-cycle pulse on a successful whack
//   miss_o         one-cycle pulse when a mole expires unwhacked
//   score_o        saturating hit count
//   miss_count_o   saturating miss count
//   state_o        FSM state: IDLE=00, SPAWN=01, UP=10, COOLDOWN=11
module mole_whack_engine #(
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int unsigned SCORE_MAX = 9999
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        tick_i,
   input  logic        game_active_i,
   input  logic [15:0] switches_i,
   output logic [15:0] leds_o,
   output logic        whack_o,
   output logic        miss_o,
   output logic [15:0] score_o,
   output logic [7:0]  miss_count_o,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      SPAWN    = 2'b01,
      UP       = 2'b10,
      COOLDOWN = 2'b11
   } state_t;

   state_t      state;
   logic [15:0] sw_s1, sw_s2, sw_s3;
   logic [15:0] edge_vec;
   logic [15:0] lfsr;
   logic        lfsr_fb;
   logic [3:0]  prev_idx;
   logic [3:0]  mole_idx;
   logic [3:0]  raw_idx;
   logic [3:0]  spawn_idx;
   logic        active_q;
   logic        hit;

   function automatic logic [15:0] sat_inc_score(input logic [15:0] v);
      if (v >= 16'(SCORE_MAX))
         sat_inc_score = 16'(SCORE_MAX);
      else
         sat_inc_score = v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc_miss(input logic [7:0] v);
      if (v == 8'hFF)
         sat_inc_miss = v;
      else
         sat_inc_miss = v + 8'd1;
   endfunction

   // s1 is the metastability stage; edges are taken between s2 and s3 so
   // each flip yields exactly one single-cycle edge bit.
   assign edge_vec = sw_s2 ^ sw_s3;
   assign hit      = edge_vec[mole_idx];

   // Taps for x^16 + x^14 + x^13 + x^11 + 1.
   assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // Never show the mole twice in the same place; bump by one (mod 16)
   // on a repeat.
   assign raw_idx   = lfsr[3:0];
   assign spawn_idx = (raw_idx == prev_idx) ? raw_idx + 4'd1 : raw_idx;

   assign state_o = state;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state        <= IDLE;
         leds_o       <= '0;
         whack_o      <= 1'b0;
         miss_o       <= 1'b0;
         score_o      <= '0;
         miss_count_o <= '0;
         lfsr         <= SEED;
         prev_idx     <= '0;
         mole_idx     <= '0;
         active_q     <= 1'b0;
         // Preload the synchroniser so switches that are already up do not
         // appear as edges.
         sw_s1        <= switches_i;
         sw_s2        <= switches_i;
         sw_s3        <= switches_i;
      end else begin
         sw_s1    <= switches_i;
         sw_s2    <= sw_s1;
         sw_s3    <= sw_s2;
         active_q <= game_active_i;
         whack_o  <= 1'b0;
         miss_o   <= 1'b0;

         if (!game_active_i) begin
            state  <= IDLE;
            leds_o <= '0;
         end else begin
            case (state)
               IDLE: begin
                  leds_o <= '0;
                  if (tick_i)
                     state <= SPAWN;
               end
               SPAWN: begin
                  lfsr     <= {lfsr[14:0], lfsr_fb};
                  prev_idx <= spawn_idx;
                  mole_idx <= spawn_idx;
                  leds_o   <= 16'd1 << spawn_idx;
                  state    <= UP;
               end
               UP: begin
                  // A whack wins over a coincident tick.
                  if (hit) begin
                     whack_o <= 1'b1;
                     score_o <= sat_inc_score(score_o);
                     leds_o  <= '0;
                     state   <= COOLDOWN;
                  end else if (tick_i) begin
                     miss_o       <= 1'b1;
                     miss_count_o <= sat_inc_miss(miss_count_o);
                     leds_o       <= '0;
                     state        <= COOLDOWN;
                  end
               end
               default: begin
                  if (tick_i)
                     state <= SPAWN;
               end
            endcase

            // A new round starts on the rising edge of game_active_i. The
            // FSM is always in IDLE then, so this never races a score update.
            if (!active_q) begin
               score_o      <= '0;
               miss_count_o <= '0;
               prev_idx     <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mole_whack_engine.sv
// Directed bench for mole_whack_engine: a cycle-by-cycle vector table,
// followed by a whack loop that drives the score to its ceiling.
module tb_mole_whack_engine;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_SPWN = 2'b01;
   localparam logic [1:0] S_UP   = 2'b10;
   localparam logic [1:0] S_COOL = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        act;
   logic [15:0] sw;
   logic [15:0] leds;
   logic        whack;
   logic        miss;
   logic [15:0] score;
   logic [7:0]  mcount;
   logic [1:0]  st;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mole_whack_engine dut (
      .clock_i      (clk),
      .reset_i      (rst),
      .tick_i       (tick),
      .game_active_i(act),
      .switches_i   (sw),
      .leds_o       (leds),
      .whack_o      (whack),
      .miss_o       (miss),
      .score_o      (score),
      .miss_count_o (mcount),
      .state_o      (st)
   );

   typedef struct {
      logic        rst;
      logic        act;
      logic        tick;
      logic [15:0] sw;
      logic [15:0] leds;
      logic        whack;
      logic        miss;
      logic [15:0] score;
      logic [7:0]  mc;
      logic [1:0]  st;
   } vec_t;

   localparam int NV = 30;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic r, input logic a, input logic t,
                               input logic [15:0] s, input logic [15:0] l,
                               input logic w, input logic m,
                               input logic [15:0] sc, input logic [7:0] mc,
                               input logic [1:0] stt);
      vec_t v;
      v.rst = r; v.act = a; v.tick = t; v.sw = s; v.leds = l;
      v.whack = w; v.miss = m; v.score = sc; v.mc = mc; v.st = stt;
      return v;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, actual, expected);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Flips the switch under the lit mole, waits out the synchroniser, and
   // then brings up the next mole. ok reports whether the whack registered
   // on the third edge.
   task automatic whack_current(output bit ok);
      int idx;
      idx = -1;
      ok  = 1'b0;
      if (!$onehot(leds)) return;
      for (int k = 0; k < 16; k++)
         if (leds[k]) idx = k;
      sw = sw ^ (16'd1 << idx);
      cycle();
      cycle();
      cycle();
      ok = (whack === 1'b1);
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      cycle();
   endtask

   initial begin
      bit ok;
      bit all_ok;
      // Expected mole positions come from stepping the LFSR by hand from 16'hACE1:
      // ACE1 -> 59C3 -> B387 -> 670F -> CE1E, which gives idx 1, 3, 7, F, E.
      //            rst  act  tick sw        leds      w  m  score mc  state
      vecs[0]  = mk(1, 0, 0, 16'hFFFF, 16'h0000, 0, 0, 16'd0, 8'd0, S_IDLE);
      vecs[1]  = mk(0, 0, 1, 16'hFFFF, 16'h0000, 0, 0, 16'd0, 8'd0, S_IDLE);
      vecs[2]  = mk(0, 1, 1, 16'hFFFF, 16'h0000, 0, 0, 16'd0, 8'd0, S_SPWN);
      vecs[3]  = mk(0, 1, 0, 16'hFFFF, 16'h0002, 0, 0, 16'd0, 8'd0, S_UP);
      vecs[4]  = mk(0, 1, 0, 16'hFFFE, 16'h0002, 0, 0, 16'd0, 8'd0, S_UP);
      vecs[5]  = mk(0, 1, 0, 16'hFFFE, 16'h0002, 0, 0, 16'd0, 8'd0, S_UP);
      vecs[6]  = mk(0, 1, 0, 16'hFFFE, 16'h0002, 0, 0, 16'd0, 8'd0, S_UP);
      vecs[7]  = mk(0, 1, 1, 16'hFFFE, 16'h0000, 0, 1, 16'd0, 8'd1, S_COOL);
      vecs[8]  = mk(0, 1, 0, 16'hFFFE, 16'h0000, 0, 0, 16'd0, 8'd1, S_COOL);
      vecs[9]  = mk(0, 1, 1, 16'hFFFE, 16'h0000, 0, 0, 16'd0, 8'd1, S_SPWN);
      vecs[10] = mk(0, 1, 1, 16'hFFFE, 16'h0008, 0, 0, 16'd0, 8'd1, S_UP);
      vecs[11] = mk(0, 1, 0, 16'hFFF6, 16'h0008, 0, 0, 16'd0, 8'd1, S_UP);
      vecs[12] = mk(0, 1, 0, 16'hFFF6, 16'h0008, 0, 0, 16'd0, 8'd1, S_UP);
      vecs[13] = mk(0, 1, 0, 16'hFFF6, 16'h0000, 1, 0, 16'd1, 8'd1, S_COOL);
      vecs[14] = mk(0, 1, 0, 16'hFFF6, 16'h0000, 0, 0, 16'd1, 8'd1, S_COOL);
      vecs[15] = mk(0, 1, 1, 16'hFFF6, 16'h0000, 0, 0, 16'd1, 8'd1, S_SPWN);
      vecs[16] = mk(0, 1, 0, 16'hFFF6, 16'h0080, 0, 0, 16'd1, 8'd1, S_UP);
      vecs[17] = mk(0, 1, 0, 16'hFF76, 16'h0080, 0, 0, 16'd1, 8'd1, S_UP);
      vecs[18] = mk(0, 1, 0, 16'hFF76, 16'h0080, 0, 0, 16'd1, 8'd1, S_UP);
      vecs[19] = mk(0, 1, 1, 16'hFF76, 16'h0000, 1, 0, 16'd2, 8'd1, S_COOL);
      vecs[20] = mk(0, 1, 1, 16'hFF76, 16'h0000, 0, 0, 16'd2, 8'd1, S_SPWN);
      vecs[21] = mk(0, 1, 0, 16'hFF76, 16'h8000, 0, 0, 16'd2, 8'd1, S_UP);
      vecs[22] = mk(0, 0, 0, 16'hFF76, 16'h0000, 0, 0, 16'd2, 8'd1, S_IDLE);
      vecs[23] = mk(0, 0, 1, 16'hFF76, 16'h0000, 0, 0, 16'd2, 8'd1, S_IDLE);
      vecs[24] = mk(0, 1, 0, 16'hFF76, 16'h0000, 0, 0, 16'd0, 8'd0, S_IDLE);
      vecs[25] = mk(0, 1, 1, 16'hFF76, 16'h0000, 0, 0, 16'd0, 8'd0, S_SPWN);
      vecs[26] = mk(0, 1, 0, 16'hFF76, 16'h4000, 0, 0, 16'd0, 8'd0, S_UP);
      vecs[27] = mk(1, 1, 1, 16'hFF76, 16'h0000, 0, 0, 16'd0, 8'd0, S_IDLE);
      vecs[28] = mk(0, 1, 1, 16'hFF76, 16'h0000, 0, 0, 16'd0, 8'd0, S_SPWN);
      vecs[29] = mk(0, 1, 0, 16'hFF76, 16'h0002, 0, 0, 16'd0, 8'd0, S_UP);

      for (int i = 0; i < NV; i++) begin
         rst  = vecs[i].rst;
         act  = vecs[i].act;
         tick = vecs[i].tick;
         sw   = vecs[i].sw;
         cycle();
         check("leds",       i, 32'(leds),   32'(vecs[i].leds));
         check("whack",      i, 32'(whack),  32'(vecs[i].whack));
         check("miss",       i, 32'(miss),   32'(vecs[i].miss));
         check("score",      i, 32'(score),  32'(vecs[i].score));
         check("miss_count", i, 32'(mcount), 32'(vecs[i].mc));
         check("state",      i, 32'(st),     32'(vecs[i].st));
      end

      // Drive the score up to its ceiling with 9999 consecutive whacks. The
      // mole is up at this point, and tick, act and rst hold their step 29 values.
      all_ok = 1'b1;
      for (int n = 0; n < 9999; n++) begin
         whack_current(ok);
         if (!ok) begin
            all_ok = 1'b0;
            break;
         end
      end
      check("whack_loop_all_hit", 0, 32'(all_ok), 32'd1);
      check("score_at_ceiling",   0, 32'(score),  32'd9999);
      check("miss_count_loop",    0, 32'(mcount), 32'd0);
      check("leds_onehot_loop",   0, 32'($onehot(leds)), 32'd1);

      // One more whack once the score is at the ceiling.
      if ($onehot(leds)) begin
         for (int k = 0; k < 16; k++)
            if (leds[k]) sw = sw ^ (16'd1 << k);
      end
      cycle();
      cycle();
      cycle();
      check("sat_whack",       0, 32'(whack),  32'd1);
      check("sat_score_held",  0, 32'(score),  32'd9999);
      check("sat_state",       0, 32'(st),     32'(S_COOL));
      check("sat_leds",        0, 32'(leds),   32'd0);
      cycle();
      check("sat_whack_pulse", 0, 32'(whack),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
